// File: rtl/cam_regfile_ctrl_pkg.sv
// Shared types, constants and helpers for the CAM register-file controller.
package cam_regfile_ctrl_pkg;

    localparam int NUM_REQ   = 3;
    localparam int REQ_IDX_W = 2;
    localparam int FFO_MAX   = 64;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_READ   = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CAM,
        EVAL,
        READ,
        RDATA,
        RESP
    } state_e;

    // Lowest set bit wins; an all-zero vector yields 0.
    function automatic int find_first_one_index(input logic [FFO_MAX-1:0] vec);
        int idx;
        idx = 0;
        for (int i = FFO_MAX - 1; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cam_ctrl_rr_arbiter.sv
// Three-requester round-robin arbiter; after a grant to X, X's successor gets top priority.
module cam_ctrl_rr_arbiter
    import cam_regfile_ctrl_pkg::*;
(
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic [REQ_IDX_W-1:0] ptr_q;
    logic [REQ_IDX_W-1:0] gnt_idx;
    logic [REQ_IDX_W-1:0] cand;

    function automatic logic [REQ_IDX_W-1:0] wrap_add(input logic [REQ_IDX_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return REQ_IDX_W'(sum);
    endfunction

    // NOTE: every always_comb target gets a default first, so no latch can be inferred.
    always_comb begin
        grant   = '0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        // Scan from lowest to highest priority so the highest-priority requester overwrites.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(ptr_q, k);
            if (req_vec[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in)                 ptr_q <= '0;
        else if (advance && |req_vec) ptr_q <= wrap_add(gnt_idx, 1);
    end

endmodule

// File: rtl/cam_regfile_controller.sv
// Sequencer/arbiter sharing one CAM/read/write register file among lookup, insert and read requesters.
module cam_regfile_controller
    import cam_regfile_ctrl_pkg::*;
#(
    parameter  int ENTRY_WIDTH = 8,
    parameter  int NUM_ENTRY   = 4,
    localparam int INDEX_WIDTH = $clog2(NUM_ENTRY)
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   lookup_valid_in,
    input  logic [ENTRY_WIDTH-1:0] lookup_key_in,
    output logic                   lookup_ready_out,
    input  logic                   insert_valid_in,
    input  logic [ENTRY_WIDTH-1:0] insert_key_in,
    output logic                   insert_ready_out,
    input  logic                   read_valid_in,
    input  logic [INDEX_WIDTH-1:0] read_index_in,
    output logic                   read_ready_out,
    input  logic                   flush_in,
    output logic                   resp_valid_out,
    input  logic                   resp_ready_in,
    output logic                   resp_hit_out,
    output logic [INDEX_WIDTH-1:0] resp_index_out,
    output logic [ENTRY_WIDTH-1:0] resp_entry_out,
    output logic                   rf_read_en_out,
    output logic                   rf_write_en_out,
    output logic                   rf_cam_en_out,
    output logic [NUM_ENTRY-1:0]   rf_read_addr_decoded_out,
    output logic [NUM_ENTRY-1:0]   rf_write_addr_decoded_out,
    output logic [ENTRY_WIDTH-1:0] rf_cam_entry_out,
    output logic [ENTRY_WIDTH-1:0] rf_write_entry_out,
    input  logic [ENTRY_WIDTH-1:0] rf_read_entry_in,
    input  logic [NUM_ENTRY-1:0]   rf_cam_result_decoded_in
);

    state_e                 state_q, state_d;
    op_e                    op_q, acc_op;
    logic [ENTRY_WIDTH-1:0] key_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [NUM_ENTRY-1:0]   valid_q;
    logic [INDEX_WIDTH-1:0] victim_q;
    logic                   resp_hit_q;
    logic [INDEX_WIDTH-1:0] resp_index_q;
    logic [ENTRY_WIDTH-1:0] resp_entry_q;

    logic [NUM_REQ-1:0]     req_vec, grant_raw, grant;
    logic                   arb_en, accept;
    logic [NUM_ENTRY-1:0]   hit_vec;
    logic                   any_hit, full, do_write;
    logic [INDEX_WIDTH-1:0] hit_idx, free_idx, target;

    assign req_vec = {read_valid_in, insert_valid_in, lookup_valid_in};
    // Readies are combinational, so reset gates them to keep every output low while reset is held.
    assign arb_en  = (state_q == IDLE) && !flush_in && !reset_in;
    assign grant   = grant_raw & {NUM_REQ{arb_en}};
    assign accept  = |grant;
    assign acc_op  = grant[OP_READ] ? OP_READ : (grant[OP_INSERT] ? OP_INSERT : OP_LOOKUP);

    assign lookup_ready_out = grant[OP_LOOKUP];
    assign insert_ready_out = grant[OP_INSERT];
    assign read_ready_out   = grant[OP_READ];

    cam_ctrl_rr_arbiter u_arbiter (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .req_vec  (req_vec),
        .advance  (accept),
        .grant    (grant_raw)
    );

    // Reset-zeroed entries would match key 0, so matches are qualified by the valid vector.
    assign hit_vec  = rf_cam_result_decoded_in & valid_q;
    assign any_hit  = |hit_vec;
    assign full     = &valid_q;
    assign hit_idx  = INDEX_WIDTH'(find_first_one_index(FFO_MAX'(hit_vec)));
    assign free_idx = INDEX_WIDTH'(find_first_one_index(FFO_MAX'(~valid_q)));
    assign target   = full ? victim_q : free_idx;
    assign do_write = (state_q == EVAL) && (op_q == OP_INSERT) && !any_hit;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d                   = state_q;
        rf_cam_en_out             = 1'b0;
        rf_cam_entry_out          = '0;
        rf_read_en_out            = 1'b0;
        rf_read_addr_decoded_out  = '0;
        rf_write_en_out           = 1'b0;
        rf_write_addr_decoded_out = '0;
        rf_write_entry_out        = '0;
        resp_valid_out            = 1'b0;
        unique case (state_q)
            IDLE: if (accept) state_d = grant[OP_READ] ? READ : CAM;
            CAM: begin
                rf_cam_en_out    = 1'b1;
                rf_cam_entry_out = key_q;
                state_d          = EVAL;
            end
            EVAL: begin
                if (do_write) begin
                    rf_write_en_out           = 1'b1;
                    rf_write_addr_decoded_out = NUM_ENTRY'(1) << target;
                    rf_write_entry_out        = key_q;
                end
                state_d = RESP;
            end
            READ: begin
                rf_read_en_out           = 1'b1;
                rf_read_addr_decoded_out = NUM_ENTRY'(1) << index_q;
                state_d                  = RDATA;
            end
            RDATA: state_d = RESP;
            RESP: begin
                resp_valid_out = 1'b1;
                if (resp_ready_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            op_q         <= OP_LOOKUP;
            key_q        <= '0;
            index_q      <= '0;
            valid_q      <= '0;
            victim_q     <= '0;
            resp_hit_q   <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= acc_op;
                key_q   <= grant[OP_INSERT] ? insert_key_in : lookup_key_in;
                index_q <= read_index_in;
            end
            if ((state_q == IDLE) && flush_in) valid_q <= '0;
            if (do_write) begin
                valid_q[target] <= 1'b1;
                if (full) victim_q <= (victim_q == INDEX_WIDTH'(NUM_ENTRY - 1)) ? '0
                                                                                  : victim_q + INDEX_WIDTH'(1);
            end
            if (state_q == EVAL) begin
                resp_hit_q   <= any_hit;
                resp_index_q <= any_hit ? hit_idx : ((op_q == OP_INSERT) ? target : '0);
                resp_entry_q <= (any_hit || (op_q == OP_INSERT)) ? key_q : '0;
            end
            if (state_q == RDATA) begin
                resp_hit_q   <= valid_q[index_q];
                resp_index_q <= index_q;
                resp_entry_q <= rf_read_entry_in;
            end
        end
    end

    assign resp_hit_out   = resp_hit_q;
    assign resp_index_out = resp_index_q;
    assign resp_entry_out = resp_entry_q;

endmodule
